uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// PURPOSE
//  UART transmit sequencer. It is driven by the 1x baud_tick from the baud generator.
//  It accepts one byte over a valid/ready handshake, then serialises it LSB-first on txd:
//  start bit, data bits, optional parity bit, stop bit(s).
//  Sits between the host-side byte source and the TX pin; the only timing reference is baud_tick.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, legal range 5..8
//  STOP_BITS   1   stop bits per frame, legal values 1 or 2
//  PARITY_ODD  0   0 = even parity, 1 = odd parity; ignored unless UART_TX_PARITY_EN is defined
// PORTS
//  clk        in   1          system clock
//  reset      in   1          synchronous, active-high reset
//  baud_tick  in   1          1-cycle pulse, one per bit period, from the baud generator
//  tx_data    in   DATA_BITS  byte to send; sampled on acceptance only
//  tx_valid   in   1          source has a byte
//  tx_ready   out  1          controller can accept; high only in IDLE
//  txd        out  1          serial line, idle high
//  busy       out  1          high in every state except IDLE
//  tx_done    out  1          1-cycle pulse on the last cycle of the final stop bit
// BEHAVIOUR
//  - Reset is synchronous, active-high, on posedge clk. It overrides all other inputs.
//    Values after reset: txd=1, tx_ready=1, busy=0, tx_done=0, state=IDLE, all counters 0.
//  - Reset in mid-frame aborts the frame. txd returns to 1 on the next edge; the partial frame is lost.
//  - All outputs are registered; there is no combinational path from any input to any output.
//  - Handshake: a byte is accepted on a clk edge where tx_valid && tx_ready.
//    On that edge tx_data is latched into the shift register and the state moves to SYNC.
//    tx_ready falls on the same edge.
//    Changes to tx_data after acceptance have no effect.
//  - FSM states: IDLE, SYNC, START, DATA, PARITY, STOP.
//    IDLE   : txd=1; accept byte -> SYNC.
//    SYNC   : txd=1; wait for baud_tick -> START. This aligns the start bit to a full bit period.
//    START  : txd=0; on baud_tick -> DATA, bit_cnt=0.
//    DATA   : txd=shift[0]; on baud_tick shift right, bit_cnt++.
//             After bit DATA_BITS-1 -> PARITY if parity is enabled, else STOP.
//    PARITY : txd=parity bit; on baud_tick -> STOP, stop_cnt=0.
//    STOP   : txd=1; on baud_tick stop_cnt++. When stop_cnt reaches STOP_BITS-1 on a baud_tick:
//             tx_done=1 for that cycle and the next state is IDLE.
//  - Timing: txd changes on the edge where baud_tick=1 is sampled, so every bit lasts exactly
//    one baud period. Line latency is 1..BAUD_CYCLE clocks from acceptance to the start-bit edge.
//  - A baud_tick in the same cycle as acceptance is ignored. SYNC waits for the next baud_tick.
//  - Back-to-back frames: tx_ready=1 on the cycle after tx_done. A new byte accepted then
//    passes through SYNC, so consecutive frames keep full stop-bit width.
//  - bit_cnt is $clog2(DATA_BITS) bits wide and stop_cnt is 1 bit wide. Neither counter wraps
//    past its terminal value; both are cleared on entry to IDLE.
//  - If baud_tick is held stuck high, the FSM advances one state/bit per clock. This is legal
//    and the frame is still well formed.
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//    - The PARITY state is present.
//    - Parity bit = ^data, XOR'd with PARITY_ODD, computed at acceptance.
//    - Frame length = 1+DATA_BITS+1+STOP_BITS bits.
//  UART_TX_PARITY_EN undefined:
//    - PARITY is never entered; DATA goes straight to STOP.
//    - PARITY_ODD is unused.
//    - Frame length = 1+DATA_BITS+STOP_BITS bits.
// TESTING
//  Bench setup: baud_tick pulses every 4 clocks. Defaults apply unless stated.
//  1. Reset released, tx_valid=0 -> txd=1, tx_ready=1, busy=0, tx_done=0, and they hold.
//  2. Send 0xA5, parity off -> txd = 0,1,0,1,0,0,1,0,1,1. Each bit lasts exactly 4 clocks.
//     One tx_done pulse at the end of the stop bit.
//  3. UART_TX_PARITY_EN, PARITY_ODD=0, send 0x07 -> parity bit=1.
//     With PARITY_ODD=1 -> parity bit=0. Frame = 11 bits.
//  4. tx_valid held high with 0x55 then 0xAA -> two complete frames; tx_ready=0 throughout frame 1.
//     Stop bit width >= 4 clocks between the frames.
//  5. STOP_BITS=2, DATA_BITS=5, send 0x1F -> 5 data 1s, then stop high for 8 clocks, then tx_done.
//  6. Assert reset in the 3rd data bit -> txd=1 and tx_ready=1 on the next edge; no tx_done pulse.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit sequencer paced by a 1x baud_tick
// Frame on txd, LSB-first: start(0), DATA_BITS data, optional parity, STOP_BITS stop(1).
// Optional parity bit is built in when UART_TX_PARITY_EN is defined (PARITY_ODD selects odd).
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   baud_tick           one-cycle pulse per bit period
//   tx_data, tx_valid   byte source; tx_data latched when tx_valid && tx_ready
//   tx_ready            high only while idle and able to accept
//   txd                 serial line, idle high
//   busy                high whenever not idle
//   tx_done             one-cycle pulse when the final stop bit completes
module uart_tx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PARITY, STOP} state_t;
  state_t state, state_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic [BW-1:0] bit_cnt, bit_cnt_d;
  logic stop_cnt, stop_cnt_d, par, par_d;
  logic txd_d, ready_d, busy_d, done_d;
  always_comb begin
    state_d = state;
    shift_d = shift;
    bit_cnt_d = bit_cnt;
    stop_cnt_d = stop_cnt;
    par_d = par;
    done_d = 1'b0;
    case (state)
      IDLE: if (tx_valid && tx_ready) begin
        state_d = SYNC;
        shift_d = tx_data;
        par_d = ^tx_data ^ PARITY_ODD;
      end
      // a tick coinciding with acceptance is ignored, so the start bit always gets a full period
      SYNC: if (baud_tick) state_d = START;
      START: if (baud_tick) begin
        state_d = DATA;
        bit_cnt_d = '0;
      end
      DATA: if (baud_tick) begin
        shift_d = shift >> 1;
        if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
          stop_cnt_d = 1'b0;
        end else begin
          bit_cnt_d = bit_cnt + 1'b1;
        end
      end
      PARITY: if (baud_tick) begin
        state_d = STOP;
        stop_cnt_d = 1'b0;
      end
      STOP: if (baud_tick) begin
        if (stop_cnt == LAST_STOP) begin
          state_d = IDLE;
          done_d = 1'b1;
        end else begin
          stop_cnt_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) begin
      bit_cnt_d = '0;
      stop_cnt_d = 1'b0;
    end
    // outputs are registered from the next state so txd moves on the tick edge itself
    txd_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] :
            (state_d == PARITY) ? par_d : 1'b1;
    // hold off acceptance during the tx_done cycle; ready returns the cycle after
    ready_d = (state_d == IDLE) && !done_d;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shift <= '0;
      bit_cnt <= '0;
      stop_cnt <= 1'b0;
      par <= 1'b0;
      txd <= 1'b1;
      tx_ready <= 1'b1;
      busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state <= state_d;
      shift <= shift_d;
      bit_cnt <= bit_cnt_d;
      stop_cnt <= stop_cnt_d;
      par <= par_d;
      txd <= txd_d;
      tx_ready <= ready_d;
      busy <= busy_d;
      tx_done <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed bench for uart_tx_ctrl with baud_tick every 4 clocks
// Instance a: defaults (8 data, 1 stop); instance b: 5 data, 2 stop.
module tb_uart_tx_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic baud_tick = 1'b0;
  logic [7:0] data_a = '0;
  logic valid_a = 1'b0;
  logic [4:0] data_b = '0;
  logic valid_b = 1'b0;
  logic txd_a, ready_a, busy_a, done_a;
  logic txd_b, ready_b, busy_b, done_b;
  logic sel = 1'b0;
  logic txd_s, ready_s, busy_s, done_s;
  int checks = 0;
  int failures = 0;
  int tcnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tcnt = (tcnt + 1) % 4;
    baud_tick = (tcnt == 0);
  end

  uart_tx_ctrl dut_a (
    .clk(clk), .reset(reset), .baud_tick(baud_tick),
    .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .txd(txd_a), .busy(busy_a), .tx_done(done_a)
  );

  uart_tx_ctrl #(.DATA_BITS(5), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .baud_tick(baud_tick),
    .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .txd(txd_b), .busy(busy_b), .tx_done(done_b)
  );

  assign txd_s = sel ? txd_b : txd_a;
  assign ready_s = sel ? ready_b : ready_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign done_s = sel ? done_b : done_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] frame(input logic [7:0] d, input int nb);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < nb; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    f[1+nb] = ^d;
`endif
    return f;
  endfunction

  function automatic int flen(input int nb, input int sb);
`ifdef UART_TX_PARITY_EN
    return 2 + nb + sb;
`else
    return 1 + nb + sb;
`endif
  endfunction

  task automatic send(input logic [7:0] d, input logic keep, input logic [7:0] nxt);
    int n;
    n = 0;
    if (sel) begin data_b = d[4:0]; valid_b = 1'b1; end
    else begin data_a = d; valid_a = 1'b1; end
    while (!ready_s && n < 40) begin step; n++; end
    check("acc_wait", 32'(n < 40), 1);
    step;
    if (sel) begin data_b = keep ? nxt[4:0] : ~d[4:0]; valid_b = keep; end
    else begin data_a = keep ? nxt : ~d; valid_a = keep; end
    check("sync_rdy", ready_s, 0);
    check("sync_busy", busy_s, 1);
  endtask

  task automatic frame_chk(input logic [7:0] d, input string tag, output logic [15:0] got);
    int nb, sb, len, lat;
    logic [15:0] exp;
    logic [3:0] v;
    logic rdy_hi, done_hi;
    nb = sel ? 5 : 8;
    sb = sel ? 2 : 1;
    exp = frame(d, nb);
    len = flen(nb, sb);
    lat = 0;
    rdy_hi = 1'b0;
    done_hi = 1'b0;
    got = '1;
    while (txd_s && lat < 10) begin step; lat++; end
    check({tag, "_lat"}, 32'(lat >= 1 && lat <= 4), 1);
    for (int j = 0; j < len; j++) begin
      for (int k = 0; k < 4; k++) begin
        v[k] = txd_s;
        rdy_hi |= ready_s;
        done_hi |= done_s;
        step;
      end
      check($sformatf("%s_bit%0d", tag, j), v, {4{exp[j]}});
      got[j] = v[0];
    end
    check({tag, "_rdy_low"}, rdy_hi, 0);
    check({tag, "_done_early"}, done_hi, 0);
    check({tag, "_done"}, done_s, 1);
    check({tag, "_done_rdy"}, ready_s, 0);
    check({tag, "_done_txd"}, txd_s, 1);
    step;
    check({tag, "_done_clr"}, done_s, 0);
    check({tag, "_rdy_back"}, ready_s, 1);
  endtask

  initial begin
    logic [15:0] got;
    logic hold_bad, seen_done, seen_low;
    int n;
    repeat (3) step;
    reset = 1'b0;
    step;
    check("rst_txd", txd_a, 1);
    check("rst_rdy", ready_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_b", {txd_b, ready_b, busy_b, done_b}, 4'b1100);
    hold_bad = 1'b0;
    repeat (8) begin
      step;
      hold_bad |= ({txd_a, ready_a, busy_a, done_a} != 4'b1100);
    end
    check("idle_hold", hold_bad, 0);

    sel = 1'b0;
    send(8'hA5, 1'b0, 8'h00);
    frame_chk(8'hA5, "a5", got);
`ifndef UART_TX_PARITY_EN
    check("a5_seq", got[9:0], 10'b1101001010);
`endif

    send(8'h07, 1'b0, 8'h00);
    frame_chk(8'h07, "x07", got);
`ifdef UART_TX_PARITY_EN
    check("x07_par", got[9], 1);
`endif

    send(8'h55, 1'b1, 8'hAA);
    frame_chk(8'h55, "b2b1", got);
    send(8'hAA, 1'b0, 8'h00);
    frame_chk(8'hAA, "b2b2", got);

    sel = 1'b1;
    send(8'h1F, 1'b0, 8'h00);
    frame_chk(8'h1F, "b1f", got);
    sel = 1'b0;

    send(8'h00, 1'b0, 8'h00);
    n = 0;
    while (txd_a && n < 10) begin step; n++; end
    repeat (13) step;
    check("mid_txd", txd_a, 0);
    check("mid_busy", busy_a, 1);
    reset = 1'b1;
    step;
    check("abort_txd", txd_a, 1);
    check("abort_rdy", ready_a, 1);
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    reset = 1'b0;
    seen_done = 1'b0;
    seen_low = 1'b0;
    repeat (50) begin
      step;
      seen_done |= done_a;
      seen_low |= !txd_a;
    end
    check("abort_no_done", seen_done, 0);
    check("abort_line_idle", seen_low, 0);
    check("abort_rdy_hold", ready_a, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
